// File: rtl/lcd_fifo_pkg.sv
// Shared types and sizes for the LCD pixel-word FIFO controller.
package lcd_fifo_pkg;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 32;

  typedef enum logic {IDLE, REQ} dma_state_t;
endpackage

// File: rtl/lcd_fifo_ctl_if.sv
// Push (DMA side) and pop (serializer side) handshakes of the pixel-word FIFO.
interface lcd_fifo_ctl_if;
  import lcd_fifo_pkg::*;

  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          pop_ready;

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/lcd_fifo_ctl.sv
// Circular-buffer controller for the 256x32 LCD pixel-word memory: write port,
// primary read port, DMA burst requests and a sticky serializer-underflow flag.
module lcd_fifo_ctl #(
  parameter int BURST = 16,
  parameter int DEPTH = 256
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        flush,
  lcd_fifo_ctl_if.slave               bus,
  output logic                        dma_req,
  output logic [lcd_fifo_pkg::AW:0]   level,
  output logic                        underflow,
  input  logic                        underflow_clr,
  output logic                        mem_write,
  output logic [lcd_fifo_pkg::AW-1:0] mem_waddr,
  output logic [lcd_fifo_pkg::DW-1:0] mem_wdata,
  output logic [lcd_fifo_pkg::AW-1:0] mem_raddr,
  input  logic [lcd_fifo_pkg::DW-1:0] mem_rdata
);
  import lcd_fifo_pkg::*;

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_W = (AW+1)'(BURST);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          underflow_q, underflow_d;
  dma_state_t    state_q, state_d;
  logic [7:0]    burst_left_q, burst_left_d;

  logic active;
  logic push_acc;
  logic pop_acc;
  logic uf_set;

  // flush and a disabled controller both hold everything in its cleared state
  assign active   = enable & ~flush;
  assign push_acc = bus.push_valid & bus.push_ready;
  assign pop_acc  = bus.pop_valid & bus.pop_ready & ~flush;
  assign uf_set   = enable & bus.pop_ready & (count_q == '0);

  assign bus.push_ready = active & (count_q != FULL);
  assign bus.pop_valid  = enable & (count_q != '0);
  assign bus.pop_data   = mem_rdata;

  assign mem_write = push_acc;
  assign mem_waddr = wptr_q;
  assign mem_wdata = bus.push_data;
  assign mem_raddr = rptr_q;

  assign level     = count_q;
  assign underflow = underflow_q;
  assign dma_req   = (state_q == REQ);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    underflow_d = underflow_q;

    if (!active) begin
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) wptr_d = wptr_q + 1'b1;
      if (pop_acc)  rptr_d = rptr_q + 1'b1;
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // a new starvation event wins over a same-cycle clear
      if (uf_set)             underflow_d = 1'b1;
      else if (underflow_clr) underflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;

    unique case (state_q)
      IDLE: begin
        if (active && ((FULL - count_q) >= BURST_W)) begin
          state_d      = REQ;
          burst_left_d = 8'(BURST);
        end
      end
      REQ: begin
        if (push_acc) begin
          if (burst_left_q == 8'd1) state_d = IDLE;
          else                      burst_left_d = burst_left_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!active) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      underflow_q  <= 1'b0;
      state_q      <= IDLE;
      burst_left_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
    end
  end
endmodule

// File: tb/tb_lcd_fifo_ctl.sv
// Directed and randomized checks of lcd_fifo_ctl against a queue-based FIFO model.
module tb_lcd_fifo_ctl;
  import lcd_fifo_pkg::*;

  localparam int BURST = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        flush;
  logic        underflow_clr;
  logic        dma_req;
  logic [8:0]  level;
  logic        underflow;
  logic        mem_write;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_raddr;
  logic [31:0] mem_rdata;

  lcd_fifo_ctl_if bus ();

  lcd_fifo_ctl #(.BURST(BURST), .DEPTH(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .flush         (flush),
    .bus           (bus.slave),
    .dma_req       (dma_req),
    .level         (level),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .mem_write     (mem_write),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  always @(posedge clk) if (mem_write) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  // Reference model: contents as a queue, plus request/underflow flags.
  logic [31:0] q [$];
  bit          m_uf;
  bit          m_req;
  int          m_left;
  int          wcnt;
  int          rcnt;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_uf   = 1'b0;
    m_req  = 1'b0;
    m_left = 0;
    wcnt   = 0;
    rcnt   = 0;
  endtask

  // One clock cycle: drive inputs after the edge, check at mid-cycle, advance model.
  task automatic cycle(input bit pv, input logic [31:0] pd, input bit pr,
                       input bit clr, input bit en, input bit fl);
    int  sz;
    bit  exp_pr, exp_pv, push, pop;
    logic [31:0] tmp;
    bus.push_valid = pv;
    bus.push_data  = pd;
    bus.pop_ready  = pr;
    underflow_clr  = clr;
    enable         = en;
    flush          = fl;
    #4;
    sz     = q.size();
    exp_pr = en && !fl && (sz != 256);
    exp_pv = en && (sz != 0);
    chk("push_ready", 32'(bus.push_ready), 32'(exp_pr));
    chk("pop_valid",  32'(bus.pop_valid),  32'(exp_pv));
    if (exp_pv) chk("pop_data", bus.pop_data, q[0]);
    chk("level",     32'(level),     32'(sz));
    chk("dma_req",   32'(dma_req),   32'(m_req));
    chk("underflow", 32'(underflow), 32'(m_uf));
    chk("mem_write", 32'(mem_write), 32'(pv && exp_pr));
    chk("mem_waddr", 32'(mem_waddr), 32'(wcnt));
    chk("mem_raddr", 32'(mem_raddr), 32'(rcnt));
    if (pv && exp_pr) chk("mem_wdata", mem_wdata, pd);

    if (!en || fl) begin
      model_clear();
    end else begin
      push = pv && (sz != 256);
      pop  = pr && (sz != 0);
      if (pr && sz == 0) m_uf = 1'b1;
      else if (clr)      m_uf = 1'b0;
      if (pop) begin
        tmp  = q.pop_front();
        rcnt = (rcnt + 1) % 256;
      end
      if (push) begin
        q.push_back(pd);
        wcnt = (wcnt + 1) % 256;
      end
      if (!m_req) begin
        if (256 - sz >= BURST) begin
          m_req  = 1'b1;
          m_left = BURST;
        end
      end else if (push) begin
        m_left--;
        if (m_left == 0) m_req = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    enable         = 1'b0;
    flush          = 1'b0;
    underflow_clr  = 1'b0;
    bus.push_valid = 1'b0;
    bus.push_data  = '0;
    bus.pop_ready  = 1'b0;
    model_clear();

    #2;
    chk("rst_push_ready", 32'(bus.push_ready), 32'd0);
    chk("rst_pop_valid",  32'(bus.pop_valid),  32'd0);
    chk("rst_dma_req",    32'(dma_req),        32'd0);
    chk("rst_level",      32'(level),          32'd0);
    chk("rst_underflow",  32'(underflow),      32'd0);
    chk("rst_mem_write",  32'(mem_write),      32'd0);
    chk("rst_mem_waddr",  32'(mem_waddr),      32'd0);
    chk("rst_mem_raddr",  32'(mem_raddr),      32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Enable: request one cycle later, then one burst of 16 words.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("req_after_enable", 32'(dma_req), 32'd1);
    for (int i = 0; i < BURST; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("req_after_burst",   32'(dma_req), 32'd0);
    chk("level_after_burst", 32'(level),   32'd16);

    // Fill from empty past full; extra pushes must be ignored.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 262; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 1'b1, 1'b0);
    chk("full_level",      32'(level),          32'd256);
    chk("full_push_ready", 32'(bus.push_ready), 32'd0);
    // Full: a simultaneous pop still leaves push_ready low.
    cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("refill_level", 32'(level), 32'd256);

    // Drain everything; pointers land back where they started.
    for (int i = 0; i < 256; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("drained_level", 32'(level),     32'd0);
    chk("drained_raddr", 32'(mem_raddr), 32'(rcnt));

    // Underflow: sticky, survives a same-cycle clear, then clears.
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("uf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("uf_set_beats_clr", 32'(underflow), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("uf_cleared", 32'(underflow), 32'd0);

    // Steady state at level 5 with push and pop every cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("steady_level", 32'(level), 32'd5);

    // Flush at level 40 mid-burst, then a fresh request.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre_flush_level", 32'(level), 32'd40);
    cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("flush_level", 32'(level),   32'd0);
    chk("flush_req",   32'(dma_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("req_after_flush", 32'(dma_req), 32'd1);

    // Randomized traffic: fill-biased, then drain-biased.
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 16) == 0,
            ($urandom % 60) != 0, ($urandom % 80) == 0);
    for (int i = 0; i < 500; i++)
      cycle(($urandom % 3) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 16) == 0,
            ($urandom % 60) != 0, ($urandom % 80) == 0);

    // Asynchronous reset in the middle of a burst.
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_dma_req",   32'(dma_req),       32'd0);
    chk("arst_level",     32'(level),         32'd0);
    chk("arst_pop_valid", 32'(bus.pop_valid), 32'd0);
    chk("arst_underflow", 32'(underflow),     32'd0);
    chk("arst_mem_waddr", 32'(mem_waddr),     32'd0);
    chk("arst_mem_raddr", 32'(mem_raddr),     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, ($urandom % 2) == 0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
